// File: rtl/seq_datapath_pkg.sv
// Shared definitions for the Mini SRC datapath slice: opcode encodings and sequencer states.
package seq_datapath_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_Y = 3'd1,
      CALC   = 3'd2,
      WB_LO  = 3'd3,
      WB_HI  = 3'd4,
      DONE   = 3'd5
   } state_e;

endpackage

// File: rtl/seq_datapath_if.sv
// Command, external register access and observation signals of the datapath slice.
interface seq_datapath_if #(
   parameter int WIDTH      = 32,
   parameter int REG_ADDR_W = 4
);
   logic                  start;
   logic [2:0]            op;
   logic [REG_ADDR_W-1:0] ra;
   logic [REG_ADDR_W-1:0] rb;
   logic [REG_ADDR_W-1:0] rc;
   logic                  load_en;
   logic [REG_ADDR_W-1:0] load_addr;
   logic [WIDTH-1:0]      load_data;
   logic [REG_ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic [WIDTH-1:0]      hi_out;
   logic [WIDTH-1:0]      lo_out;
   logic [WIDTH-1:0]      bus_out;
   logic                  busy;
   logic                  done;

   modport master (
      output start, op, ra, rb, rc, load_en, load_addr, load_data, rd_addr,
      input  rd_data, hi_out, lo_out, bus_out, busy, done
   );

   modport slave (
      input  start, op, ra, rb, rc, load_en, load_addr, load_data, rd_addr,
      output rd_data, hi_out, lo_out, bus_out, busy, done
   );

endinterface

// File: rtl/seq_datapath_alu_core.sv
// Combinational ALU: computes Z from Y and the bus value; only MUL fills the upper half.
module alu_core
   import seq_datapath_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]   y,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         op,
   output logic [2*WIDTH-1:0] result
);
   localparam int SHW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] y_ext;
   logic [2*WIDTH-1:0] b_ext;

   // Sign-extending both operands makes the low 2*WIDTH bits of the product the signed result.
   assign y_ext = {{WIDTH{y[WIDTH-1]}}, y};
   assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

   always_comb begin
      // NOTE: result gets a default before the case so every path assigns it and no latch is inferred.
      result = '0;
      case (op)
         OP_ADD:  result[WIDTH-1:0] = y + b;
         OP_SUB:  result[WIDTH-1:0] = y - b;
         OP_AND:  result[WIDTH-1:0] = y & b;
         OP_OR:   result[WIDTH-1:0] = y | b;
         OP_MUL:  result            = y_ext * b_ext;
         OP_NOT:  result[WIDTH-1:0] = ~y;
         OP_SHR:  result[WIDTH-1:0] = y >> b[SHW-1:0];
         default: result            = '0;
      endcase
   end

endmodule

// File: rtl/seq_datapath.sv
// Mini SRC datapath slice: register file, Y/Z/HI/LO, single internal bus and the
// control-step sequencer that walks one register-register instruction through them.
module seq_datapath
   import seq_datapath_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int NUM_REGS   = 16,
   parameter int REG_ADDR_W = 4,
   parameter bit ZERO_R0    = 1'b1
) (
   input  logic         clock,
   input  logic         clear,
   seq_datapath_if.slave io
);

   state_e                state_q, state_d;
   logic [2:0]            op_q;
   logic [REG_ADDR_W-1:0] ra_q, rb_q, rc_q;
   logic [WIDTH-1:0]      regs_q [NUM_REGS];
   logic [WIDTH-1:0]      y_q, hi_q, lo_q;
   logic [2*WIDTH-1:0]    z_q;

   logic                  can_accept;
   logic                  accept;
   logic [WIDTH-1:0]      rb_val, rc_val, bus;
   logic [2*WIDTH-1:0]    alu_res;
   logic                  wr_en;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;

   // Out-of-range indices and (optionally) R0 are neither readable nor writable.
   function automatic logic reg_live(input logic [REG_ADDR_W-1:0] a);
      return (int'(a) < NUM_REGS) && !(ZERO_R0 && (a == '0));
   endfunction

   assign can_accept = (state_q == IDLE) || (state_q == DONE);
   assign accept     = io.start && can_accept;

   always_comb begin
      rb_val     = '0;
      rc_val     = '0;
      io.rd_data = '0;
      if (reg_live(rb_q))       rb_val     = regs_q[rb_q];
      if (reg_live(rc_q))       rc_val     = regs_q[rc_q];
      if (reg_live(io.rd_addr)) io.rd_data = regs_q[io.rd_addr];
   end

   always_comb begin
      bus = '0;
      case (state_q)
         LOAD_Y:  bus = rb_val;
         CALC:    bus = rc_val;
         WB_LO:   bus = z_q[WIDTH-1:0];
         WB_HI:   bus = z_q[2*WIDTH-1:WIDTH];
         default: bus = '0;
      endcase
   end

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .y      (y_q),
      .b      (bus),
      .op     (op_q),
      .result (alu_res)
   );

   // External loads and op write-back occupy disjoint states, so one write port serves both.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = ra_q;
      wr_data = bus;
      if (can_accept) begin
         wr_en   = io.load_en;
         wr_addr = io.load_addr;
         wr_data = io.load_data;
      end else if (state_q == WB_LO && op_q != OP_MUL && op_q != OP_NOP) begin
         wr_en = 1'b1;
      end
      if (!reg_live(wr_addr)) wr_en = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (io.start) state_d = LOAD_Y;
         LOAD_Y:  state_d = CALC;
         CALC:    state_d = WB_LO;
         WB_LO:   state_d = (op_q == OP_MUL) ? WB_HI : DONE;
         WB_HI:   state_d = DONE;
         DONE:    state_d = io.start ? LOAD_Y : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, like real flops.
      if (clear) begin
         state_q <= IDLE;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
         y_q     <= '0;
         z_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= io.op;
            ra_q <= io.ra;
            rb_q <= io.rb;
            rc_q <= io.rc;
         end
         if (state_q == LOAD_Y)                   y_q  <= bus;
         if (state_q == CALC)                     z_q  <= alu_res;
         if (state_q == WB_LO && op_q == OP_MUL)  lo_q <= bus;
         if (state_q == WB_HI)                    hi_q <= bus;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      // NOTE: the register file is reset on purpose; clear must leave every general register at zero.
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   assign io.bus_out = bus;
   assign io.hi_out  = hi_q;
   assign io.lo_out  = lo_q;
   assign io.busy    = (state_q == LOAD_Y) || (state_q == CALC) ||
                       (state_q == WB_LO)  || (state_q == WB_HI);
   assign io.done    = (state_q == DONE);

endmodule
